// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
// Optional flag outputs are enabled by defining ADDSUB_FLAGS_EN.
package addsub_pkg;

    // Operation select values for the sub input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Number of pipeline stages: one CHUNK-bit slice per stage
    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_rca_addsub_if.sv
// Operand/result bus of the pipelined adder/subtractor. The slave modport is the
// adder's view, the master modport is the producer/consumer view.
// Defining ADDSUB_FLAGS_EN adds the zero/neg/ovf result flags.
interface pipelined_rca_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDSUB_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDSUB_FLAGS_EN
        , input zero, neg, ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDSUB_FLAGS_EN
        , output zero, neg, ovf
`endif
    );

endinterface

// File: rtl/pipelined_rca_addsub_chunk.sv
// Combinational W-bit ripple-carry adder slice. Also exposes the carry into the
// slice MSB so the top slice can derive signed overflow.
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o,
    output logic         c_msb_in_o
);

    logic [W:0] c;

    // Bit-serial ripple: sum bit and generate/propagate carry per position
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o     = c[W];
    assign c_msb_in_o = c[W-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry
// ripples one slice per clock, full throughput with valid/ready on both sides.
// Upper operand slices and finished lower sum slices travel with each beat.
// in_ready is combinational from out_ready (no skid buffer).
// Define ADDSUB_FLAGS_EN to add registered zero/neg/ovf outputs.
module pipelined_rca_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_rca_addsub_if.slave bus
);

    localparam int STAGES = stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_err
        $error("pipelined_rca_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    logic              advance;

    // Stage inputs (also next state of the pass-through registers)
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic              ci_d  [STAGES];
    logic              v_d   [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];

    // Slice adder outputs
    logic [CHUNK-1:0]  s_w   [STAGES];
    logic [STAGES-1:0] co_w;
    logic [STAGES-1:0] cmsb_w;

    // Stage registers
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;

    // Only the top slice's MSB carry feeds ovf; the rest are intentionally dropped
    logic              unused_cmsb;
    assign unused_cmsb = ^cmsb_w;

    assign advance       = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];

    // Stage 0 takes the bus (B inverted and carry flipped for subtract); later stages take the previous registers
    always_comb begin
        a_d[0]  = bus.a;
        b_d[0]  = (bus.sub == SUB) ? ~bus.b : bus.b;
        ci_d[0] = bus.cin ^ bus.sub;
        v_d[0]  = bus.in_valid;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            ci_d[k] = c_q[k-1];
            v_d[k]  = v_q[k-1];
            s_in[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        rca_chunk #(.W(CHUNK)) u_chunk (
            .a_i        (a_d[k][k*CHUNK +: CHUNK]),
            .b_i        (b_d[k][k*CHUNK +: CHUNK]),
            .cin_i      (ci_d[k]),
            .s_o        (s_w[k]),
            .cout_o     (co_w[k]),
            .c_msb_in_o (cmsb_w[k])
        );
    end

    // Merge each stage's freshly computed slice into the skewed partial sum
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_in[k];
            s_d[k][k*CHUNK +: CHUNK] = s_w[k];
        end
    end

    // All stages shift together on advance and hold (data included) on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= co_w[k];
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;

    // Flags are registered alongside the last stage so they align with sum
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            zero_q <= (s_d[LAST] == '0);
            neg_q  <= s_d[LAST][WIDTH-1];
            ovf_q  <= co_w[LAST] ^ cmsb_w[LAST];
        end
    end

    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Self-checking bench for pipelined_rca_addsub (WIDTH=16, CHUNK=4).
// Flag outputs are checked when ADDSUB_FLAGS_EN is defined.
module tb_pipelined_rca_addsub;
    import addsub_pkg::*;

    localparam int W   = 16;
    localparam int C   = 4;
    localparam int STG = W / C;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_rca_addsub_if #(.WIDTH(W)) bus ();

    pipelined_rca_addsub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W:0] res;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         n_chk   = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    bit         lat_chk = 1'b1;
    bit         held_v  = 1'b0;
    logic [W:0] held;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb, input int c);
        exp_t e;
        int   r;
        int   sr;
        if (sb == SUB) begin
            r  = int'(a) - int'(b) - int'(ci) + (1 << W);
            sr = int'($signed(a)) - int'($signed(b)) - int'(ci);
        end else begin
            r  = int'(a) + int'(b) + int'(ci);
            sr = int'($signed(a)) + int'($signed(b)) + int'(ci);
        end
        e.res = r[W:0];
        e.ovf = (sr > 32767) || (sr < -32768);
        e.cyc = c;
        return e;
    endfunction

    // Scoreboard: record accepted beats, check every retired beat and stall stability
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid_hold", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_data_hold", {15'd0, bus.cout, bus.sum}, {15'd0, held});
            end
            held_v = 1'b0;
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, cyc));
            if (bus.out_valid) begin
                if (!bus.out_ready) begin
                    held_v = 1'b1;
                    held   = {bus.cout, bus.sum};
                end else if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL stale_beat: out_valid=1 sum=%h with no beat outstanding", bus.sum);
                end else begin
                    e = q.pop_front();
                    chk("result", {15'd0, bus.cout, bus.sum}, {15'd0, e.res});
`ifdef ADDSUB_FLAGS_EN
                    chk("flag_zero", {31'd0, bus.zero}, {31'd0, (e.res[W-1:0] == '0)});
                    chk("flag_neg",  {31'd0, bus.neg},  {31'd0, e.res[W-1]});
                    chk("flag_ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
`endif
                    if (lat_chk) chk("latency", cyc - e.cyc, STG);
                end
            end
        end
        cyc++;
    end

    task automatic chk_reset_state(input string nm);
        chk({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({nm, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        chk({nm, "_sum"},       {16'd0, bus.sum},       32'd0);
        chk({nm, "_cout"},      {31'd0, bus.cout},      32'd0);
`ifdef ADDSUB_FLAGS_EN
        chk({nm, "_flags"}, {29'd0, bus.zero, bus.neg, bus.ovf}, 32'd0);
`endif
    endtask

    // Single beat with hand-computed expectations; called at posedge+1 with out_ready=1
    task automatic op_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input logic [W-1:0] es,
                          input logic ec, input logic ez, input logic en, input logic eo);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && n < 3 * STG) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, STG);
        chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_sum"},   {16'd0, bus.sum}, {16'd0, es});
        chk({nm, "_cout"},  {31'd0, bus.cout}, {31'd0, ec});
`ifdef ADDSUB_FLAGS_EN
        chk({nm, "_zero"}, {31'd0, bus.zero}, {31'd0, ez});
        chk({nm, "_neg"},  {31'd0, bus.neg},  {31'd0, en});
        chk({nm, "_ovf"},  {31'd0, bus.ovf},  {31'd0, eo});
`else
        if (ez && en && eo) $display("note: flag expectations unused in this build");
`endif
        @(posedge clk); #1;
    endtask

    task automatic rand_fields();
        bus.a   = W'($urandom_range(0, 65535));
        bus.b   = W'($urandom_range(0, 65535));
        bus.cin = 1'($urandom_range(0, 1));
        bus.sub = 1'($urandom_range(0, 1));
    endtask

    // Hold a random beat until accepted; called at posedge+1
    task automatic send_rand();
        int n = 0;
        bus.in_valid = 1'b1;
        rand_fields();
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = ADD;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Hand-computed cases
        op_lit("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, ADD, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        op_lit("5_minus_7",   16'h0005, 16'h0007, 1'b0, SUB, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0);
        op_lit("5_minus_7_b", 16'h0005, 16'h0007, 1'b1, SUB, 16'hFFFD, 1'b0, 1'b0, 1'b1, 1'b0);
        op_lit("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, ADD, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        op_lit("9_minus_9",   16'h0009, 16'h0009, 1'b0, SUB, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Ten back-to-back random beats, consumer always ready
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            rand_fields();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (STG + 2) @(posedge clk);
        #1;
        chk("burst_drained", q.size(), 0);

        // Fill the pipeline with the consumer stalled, then stall five cycles
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < STG; i++) begin
            bus.in_valid = 1'b1;
            rand_fields();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        rand_fields();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send_rand();
        send_rand();
        repeat (STG + 3) @(posedge clk);
        #1;
        chk("stall_drained", q.size(), 0);

        // Random valid/ready traffic
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            rand_fields();
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STG + 3) @(posedge clk);
        #1;
        chk("random_drained", q.size(), 0);

        // Reset with three beats in flight
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            rand_fields();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("midreset");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        op_lit("after_reset", 16'h1234, 16'h0F0F, 1'b1, ADD, 16'h2144, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (STG + 2) @(posedge clk);
        #1;
        chk("final_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_rca_addsub.md
Name: pipelined_rca_addsub

Overview:
Parametrised, pipelined ripple-carry adder/subtractor with carry-in, carry-out and a valid/ready handshake on both sides.
- Operand width is split into CHUNK-bit slices. Each slice is one pipeline stage, so carry ripples one slice per clock.
- Full throughput: one operation per cycle.
- Sits between operand registers and result consumers in the datapath. Replaces single-cycle fixed-width adders where timing or width demands it.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (CHUNK = WIDTH gives 1 stage).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out; for sub, 1 means no borrow.

Behaviour:
- Arithmetic:
  - Effective B = sub ? ~b : b.
  - Effective carry-in = cin ^ sub.
  - {cout,sum} = a + effB + effCin, computed mod 2^(WIDTH+1).
  - So sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- Pipeline:
  - STAGES register stages. Stage k adds slice k and registers its sum slice plus carry to slice k+1.
  - Unprocessed upper operand slices and already-computed lower sum slices travel alongside in skew registers.
- Valid:
  - Each stage carries a valid bit.
  - out_valid and sum/cout are driven from the last stage.
- Latency: exactly STAGES cycles from an accepted beat (in_valid && in_ready) to out_valid, when there is no stall.
- Flow control:
  - advance = !out_valid || out_ready.
  - All stages shift only when advance = 1; in_ready = advance.
  - On stall, every stage register holds, including data.
  - in_ready depends combinationally on out_ready (documented; no skid buffer).
- Bubbles: a cycle with advance = 1 and in_valid = 0 inserts a bubble (valid = 0) into stage 0. Bubbles are not compressed.
- Simultaneous events:
  - With a full pipeline, out_ready = 1 and in_valid = 1 in the same cycle, the block retires one beat and accepts one beat.
  - No loss and no duplication.
- Output stability: while out_valid && !out_ready, sum/cout hold stable.
- Reset:
  - All stage valid bits clear: out_valid = 0, sum = 0, cout = 0, in_ready = 1 in the cycle after rst.
  - Reset mid-operation discards all in-flight beats; nothing emerges afterwards.
- Static check: WIDTH % CHUNK != 0 is a parameter error (elaboration assertion).

Optional Feature:
Macro ADDSUB_FLAGS_EN.
- Defined:
  - Extra outputs zero, neg and ovf (1 bit each), aligned with sum and held under stall.
  - zero = (sum == 0).
  - neg = sum[WIDTH-1].
  - ovf = signed overflow: carry into MSB ^ carry out of MSB.
  - All three reset to 0.
- Undefined: the ports and their logic do not exist.

Decomposition:
- Package addsub_pkg holds:
  - mode constants ADD = 1'b0, SUB = 1'b1;
  - function stages(WIDTH, CHUNK).
- Sub-module rca_chunk: combinational CHUNK-bit ripple adder, (a, b, cin) -> (s, cout, c_msb_in). c_msb_in is used for ovf.
- pipelined_rca_addsub instantiates one rca_chunk per stage in a generate loop.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4.
1. a=FFFF, b=0001, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=0000, cout=1; ovf=0, zero=1 if flags enabled.
2. a=0005, b=0007, cin=0, sub=1 -> sum=FFFE, cout=0 (borrow), neg=1. Then cin=1 -> sum=FFFD.
3. a=7FFF, b=0001, add -> sum=8000, cout=0, ovf=1, neg=1.
4. Random beats on 10 consecutive cycles with out_ready=1 -> 10 results on 10 consecutive cycles, in order, matching the reference model.
5. Fill the pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, sum stable. Release -> all beats emerge in order, none dropped or duplicated.
6. Assert rst with 3 beats in flight -> next cycle out_valid=0, in_ready=1. No stale beat ever appears.
